adq_temp: RTL and testbench

Periodic temperature acquisition front end: drives a serial ADC (8-bit, MSB first, read-only SPI-style link), quantizes each sample to a 3-bit temperature level and presents it on `dato` with a one-cycle `leer` strobe. It is the producing end of the temperature register's load interface. `dato`/`leer` connect directly to that register's `dato`/`leer` inputs, and both blocks share `clk` and `EN`.

---
 rtl/adq_temp.sv | 119 +++++++++++
 tb/tb_adq_temp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adq_temp.sv
// adq_temp: periodic temperature acquisition front end.
// Reads an 8-bit serial ADC (MSB first, sampled on sclk rising edges),
// keeps the 3 MSBs as the temperature level and strobes it out on leer.
module adq_temp #(
    parameter int DIV     = 4,     // clk cycles per sclk half-period (>=1)
    parameter int PERIODO = 1000   // idle cycles between conversions (>=2)
) (
    input  logic       clk,
    input  logic       EN,
    input  logic       miso,
    output logic       cs_n,
    output logic       sclk,
    output logic [2:0] dato,
    output logic       leer,
    output logic       ocupado
);

    localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        INICIO   = 2'd1,
        TRANSFER = 2'd2,
        FIN      = 2'd3
    } estado_t;

    estado_t         estado;
    logic [PW-1:0]   per_cnt;
    logic [DW-1:0]   div_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      muestra;
    logic            div_fin;
    logic            muestrear;

    // End of one sclk half-period (or of the INICIO/FIN hold)
    assign div_fin   = (div_cnt == DW'(DIV - 1));
    // Sample miso exactly when the sclk register is about to go 0 -> 1
    assign muestrear = (estado == TRANSFER) && div_fin && !sclk;

    // Conversion sequencer with registered ADC and load-interface outputs
    always_ff @(posedge clk or negedge EN) begin
        if (!EN) begin
            estado  <= REPOSO;
            per_cnt <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b1;
            dato    <= 3'b000;
            leer    <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            leer <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (per_cnt == PW'(PERIODO - 1)) begin
                        per_cnt <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        cs_n    <= 1'b0;
                        ocupado <= 1'b1;
                        estado  <= INICIO;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                INICIO: begin
                    if (div_fin) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        estado  <= TRANSFER;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                TRANSFER: begin
                    if (div_fin) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (!sclk) begin
                            // 3-bit counter wraps 7 -> 0 on the last rising edge
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                estado <= FIN;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (div_fin) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        ocupado <= 1'b0;
                        dato    <= muestra[7:5];
                        leer    <= 1'b1;
                        per_cnt <= '0;
                        estado  <= REPOSO;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

    // Sample shift register; fully rewritten before every publish, so no reset
    always_ff @(posedge clk) begin
        if (muestrear) begin
            muestra <= {muestra[6:0], miso};
        end
    end

endmodule

// File: tb/tb_adq_temp.sv
// Bench for adq_temp: one instance with DIV=2/PERIODO=10 driven by a
// table of ADC words, one with DIV=1/PERIODO=2 converting 0x80 repeatedly.
module tb_adq_temp;

    logic       clk;
    logic       EN, miso, cs_n, sclk, leer, ocupado;
    logic [2:0] dato;
    logic       EN1, miso1, cs_n1, sclk1, leer1, ocupado1;
    logic [2:0] dato1;

    adq_temp #(.DIV(2), .PERIODO(10)) dut (
        .clk(clk), .EN(EN), .miso(miso), .cs_n(cs_n), .sclk(sclk),
        .dato(dato), .leer(leer), .ocupado(ocupado)
    );

    adq_temp #(.DIV(1), .PERIODO(2)) dut1 (
        .clk(clk), .EN(EN1), .miso(miso1), .cs_n(cs_n1), .sclk(sclk1),
        .dato(dato1), .leer(leer1), .ocupado(ocupado1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] sample;
        logic [2:0] expv;
        logic       publish;
    } vec_t;

    vec_t vec [6];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // scoreboard for dut
    logic [7:0] adc_q [$];
    logic [2:0] exp_q [$];
    logic [7:0] adc_word = 8'h00;
    int idx = 0, rises = 0, last_rise = 0, t0 = 0, falls = 0, leers = 0, leer_t = -1, rel = 0;
    logic cs_q = 1'b1, sclk_q = 1'b1, leer_q = 1'b0, en_q = 1'b0;
    logic [2:0] dato_q = 3'b000;

    // state for dut1
    int idx1 = 0, rises1 = 0, last_rise1 = 0, t01 = 0, leers1 = 0, rel1 = 0;
    logic cs1_q = 1'b1, sclk1_q = 1'b1, leer1_q = 1'b0, first1 = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_reset_dut();
        check("rst cs_n", cs_n, 1);
        check("rst sclk", sclk, 1);
        check("rst dato", dato, 0);
        check("rst leer", leer, 0);
        check("rst ocupado", ocupado, 0);
    endtask

    // One clock: sample #1 after the edge, run ADC models and monitors
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        // ---- dut ----
        if (!cs_n && cs_q) begin
            t0 = cyc; rises = 0; idx = 0; falls++;
            adc_word = (adc_q.size() > 0) ? adc_q.pop_front() : 8'h00;
        end
        if (sclk && !sclk_q && !cs_n) begin
            rises++;
            if (rises > 1) check("sclk rise spacing", cyc - last_rise, 4);
            last_rise = cyc;
        end
        if (!sclk && sclk_q && idx < 8) begin
            miso = adc_word[7 - idx];
            idx++;
        end
        check("ocupado vs cs_n", ocupado, !cs_n);
        if (leer) begin
            leers++;
            check("leer width", leer_q, 0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected leer: got dato=%0d want no strobe (cycle %0d)", dato, cyc);
            end else begin
                check("dato at leer", dato, exp_q.pop_front());
            end
            check("leer latency", cyc - t0, 34);
            check("sclk rise count", rises, 8);
            if (leer_t >= 0) check("leer period", cyc - leer_t, 44);
            leer_t = cyc;
        end else if (EN && en_q) begin
            check("dato hold", dato, dato_q);
        end
        leer_q = leer; cs_q = cs_n; sclk_q = sclk; dato_q = dato; en_q = EN;
        // ---- dut1 ----
        if (!cs_n1 && cs1_q) begin
            if (!first1) begin
                check("dut1 first cs_n fall", cyc - rel1, 2);
                first1 = 1'b1;
            end
            t01 = cyc; rises1 = 0; idx1 = 0;
        end
        if (sclk1 && !sclk1_q && !cs_n1) begin
            rises1++;
            if (rises1 > 1) check("dut1 rise spacing", cyc - last_rise1, 2);
            last_rise1 = cyc;
        end
        if (!sclk1 && sclk1_q) begin
            miso1 = (idx1 == 0);
            idx1++;
        end
        if (leer1) begin
            leers1++;
            check("dut1 leer width", leer1_q, 0);
            check("dut1 dato", dato1, 3'b100);
            check("dut1 leer latency", cyc - t01, 17);
            check("dut1 rise count", rises1, 8);
        end
        leer1_q = leer1; cs1_q = cs_n1; sclk1_q = sclk1;
    endtask

    initial begin
        int n;
        vec[0] = '{8'hB3, 3'b101, 1'b1};   // stream 1,0,1,1,0,0,1,1
        vec[1] = '{8'hFF, 3'b111, 1'b1};
        vec[2] = '{8'h1F, 3'b000, 1'b1};
        vec[3] = '{8'h5A, 3'b010, 1'b1};
        vec[4] = '{8'h80, 3'b100, 1'b0};   // aborted by reset, never published
        vec[5] = '{8'hB3, 3'b101, 1'b1};

        EN = 1'b0; EN1 = 1'b0; miso = 1'b0; miso1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            miso  = 1'($urandom_range(0, 1));
            miso1 = 1'($urandom_range(0, 1));
            step();
            check_reset_dut();
            check("dut1 rst cs_n", cs_n1, 1);
            check("dut1 rst sclk", sclk1, 1);
            check("dut1 rst leer", leer1, 0);
        end

        for (int i = 0; i < 6; i++) begin
            adc_q.push_back(vec[i].sample);
            if (vec[i].publish) exp_q.push_back(vec[i].expv);
        end

        EN = 1'b1; EN1 = 1'b1; rel = cyc; rel1 = cyc;

        n = 0;
        while (falls < 1 && n < 30) begin step(); n++; end
        check("first cs_n fall", t0 - rel, 10);

        n = 0;
        while (leers < 4 && n < 260) begin step(); n++; end
        check("four leer pulses", leers, 4);

        // reset in the middle of the fifth transfer
        n = 0;
        while (!(falls == 5 && rises == 4) && n < 80) begin step(); n++; end
        check("reached 4th rise", int'(falls == 5 && rises == 4), 1);
        EN = 1'b0;
        #1;
        check_reset_dut();
        for (int i = 0; i < 5; i++) begin
            step();
            check_reset_dut();
        end
        EN = 1'b1; rel = cyc; leer_t = -1;

        n = 0;
        while (falls < 6 && n < 30) begin step(); n++; end
        check("cs_n fall after abort", t0 - rel, 10);
        check("no leer during abort", leers, 4);

        n = 0;
        while (leers < 5 && n < 60) begin step(); n++; end
        check("leer after abort", leers, 5);
        for (int i = 0; i < 4; i++) step();
        check("scoreboard drained", exp_q.size(), 0);
        check("dut1 conversions seen", int'(leers1 >= 10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
